// File: rtl/edge_bit_packer.sv
// edge_bit_packer: packs the Sobel edge-bit stream into bytes, buffers them in a FWFT FIFO and counts edges per frame
//   clk, rst (async, active-high)
//   edge_in/edge_valid            : edge bit stream, no backpressure
//   byte_out/byte_last/byte_valid : FIFO head, byte_ready accepts it
//   edge_count/count_valid        : edge tally of the last frame, one-cycle update pulse
//   overflow                      : sticky, a committed byte was dropped
module edge_bit_packer #(
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        edge_in,
   input  logic        edge_valid,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        byte_last,
   output logic [16:0] edge_count,
   output logic        count_valid,
   output logic        overflow
);
   localparam int PPF = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
   localparam int PW  = (PPF > 1) ? $clog2(PPF) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   logic [PW-1:0] pix_cnt;
   logic [2:0]    bit_idx;
   logic [6:0]    pack;
   logic [16:0]   tally;
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic          mem_l [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          frame_end, commit, empty, full, rd, wr;
   logic [7:0]    wdata;
   assign frame_end   = edge_valid && pix_cnt == PW'(PPF - 1);
   assign commit      = edge_valid && (bit_idx == 3'd7 || frame_end);
   // pack only ever holds bits below bit_idx, so upper bits of a short final byte are already 0
   assign wdata       = {1'b0, pack} | (8'(edge_in) << bit_idx);
   assign empty       = wr_ptr == rd_ptr;
   assign full        = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
   assign rd          = !empty && byte_ready;
   // a read on the same edge frees the slot, so a write into a full FIFO is still accepted
   assign wr          = commit && (!full || rd);
   assign byte_valid  = !empty;
   assign byte_out    = empty ? 8'd0 : mem_d[rd_ptr[AW-1:0]];
   assign byte_last   = empty ? 1'b0 : mem_l[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_d[wr_ptr[AW-1:0]] <= wdata;
         mem_l[wr_ptr[AW-1:0]] <= frame_end;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt     <= '0;
         bit_idx     <= '0;
         pack        <= '0;
         tally       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         edge_count  <= '0;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         count_valid <= frame_end;
         if (edge_valid) begin
            pix_cnt <= frame_end ? '0 : pix_cnt + 1'b1;
            bit_idx <= commit ? 3'd0 : bit_idx + 3'd1;
            pack    <= commit ? 7'd0 : pack | (7'(edge_in) << bit_idx);
            tally   <= frame_end ? 17'd0 : tally + 17'(edge_in);
         end
         if (frame_end) edge_count <= tally + 17'(edge_in);
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         if (commit && !wr) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_edge_bit_packer.sv
// tb_edge_bit_packer: randomized and directed checks of edge_bit_packer against a queue-based frame model
module tb_edge_bit_packer;
   localparam int W = 5, H = 6, D = 4;
   localparam int PPF = (W - 2) * (H - 2);
   logic        clk = 1'b0, rst = 1'b1;
   logic        edge_in = 1'b0, edge_valid = 1'b0, byte_ready = 1'b0;
   logic [7:0]  byte_out;
   logic        byte_valid, byte_last, count_valid, overflow;
   logic [16:0] edge_count;
   int          vecs = 0, errs = 0;
   logic [8:0]  q[$];
   int          pix, nbits, tally, ecount;
   logic [7:0]  acc;
   bit          cvalid, ovf;
   edge_bit_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .edge_in(edge_in), .edge_valid(edge_valid),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .byte_last(byte_last), .edge_count(edge_count), .count_valid(count_valid),
      .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_clear();
      q.delete();
      pix = 0; nbits = 0; tally = 0; ecount = 0; acc = 0; cvalid = 0; ovf = 0;
   endtask
   task automatic compare();
      chk("byte_valid", 32'(byte_valid), 32'(q.size() > 0));
      chk("byte_out", 32'(byte_out), q.size() > 0 ? 32'(q[0][7:0]) : 0);
      chk("byte_last", 32'(byte_last), q.size() > 0 ? 32'(q[0][8]) : 0);
      chk("edge_count", 32'(edge_count), 32'(ecount));
      chk("count_valid", 32'(count_valid), 32'(cvalid));
      chk("overflow", 32'(overflow), 32'(ovf));
   endtask
   task automatic step(input bit v, input bit e, input bit r);
      bit rd, full, cm, last;
      logic [8:0] ent;
      @(negedge clk);
      compare();
      rd = r && q.size() > 0;
      full = q.size() == D;
      cm = 0; last = 0; cvalid = 0;
      if (v) begin
         acc[nbits] = e;
         nbits++; pix++; tally += int'(e);
         cm = nbits == 8 || pix == PPF;
         last = pix == PPF;
         ent = {last, acc};
         if (cm) begin nbits = 0; acc = 0; end
         if (last) begin ecount = tally; tally = 0; pix = 0; cvalid = 1; end
      end
      if (rd) void'(q.pop_front());
      if (cm) begin
         if (!full || rd) q.push_back(ent);
         else ovf = 1;
      end
      edge_valid = v; edge_in = e; byte_ready = r;
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      edge_valid = 1'b0; byte_ready = 1'b0;
      #1;
      chk("rst_byte_valid", 32'(byte_valid), 0);
      chk("rst_byte_out", 32'(byte_out), 0);
      chk("rst_byte_last", 32'(byte_last), 0);
      chk("rst_edge_count", 32'(edge_count), 0);
      chk("rst_count_valid", 32'(count_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask
   initial begin
      model_clear();
      do_reset();
      for (int i = 0; i < PPF; i++) step(1, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 10; i++) step(0, 0, 1);
      do_reset();
      for (int i = 0; i < 100 && !(q.size() == D && (nbits == 7 || pix == PPF - 1)); i++)
         step(1, 1'($urandom_range(0, 1)), 0);
      step(1, 1'($urandom_range(0, 1)), 1);
      step(0, 0, 0);
      chk("rw_full_no_ovf", 32'(overflow), 0);
      chk("rw_full_valid", 32'(byte_valid), 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
      do_reset();
      for (int i = 0; i < 40; i++) step(1, 1'($urandom_range(0, 1)), 0);
      step(0, 0, 0);
      chk("ovf_set", 32'(overflow), 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
      chk("ovf_sticky", 32'(overflow), 1);
      for (int i = 0; i < 13; i++) step(1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      do_reset();
      for (int i = 0; i < PPF + 3; i++) step(i < PPF, 1'($urandom_range(0, 1)), 1);
      for (int i = 0; i < 4; i++) step(0, 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
